// File: rtl/inference_sequencer.sv
// inference_sequencer: control sequencer for an N x N weight-stationary
// systolic inference array. It drives weight-row loading, input-vector
// streaming, array drain and output-row capture. Weights stay resident
// across runs, so repeated inferences do not reload them.
//
// Optional build macro INFSEQ_STALL_CNT_EN adds a 16-bit stall_cycles output.
// It counts stalled cycles (enable=0) while busy. The count clears on each
// accepted run, so it holds the total for the run once done has pulsed.
module inference_sequencer #(
  parameter int N      = 8,
  parameter int MAX_IN = 64,
  parameter int CNT_W  = $clog2(MAX_IN + 1),
  parameter int LAT    = 2 * N - 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 enable,
  input  logic                 start_weights,
  input  logic                 start_array,
  input  logic [CNT_W-1:0]     num_input,
  output logic                 weight_load,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] weight_row,
  output logic                 input_valid,
  output logic [CNT_W-1:0]     input_idx,
  output logic                 out_valid,
  output logic [CNT_W-1:0]     out_idx,
  output logic                 weights_loaded,
  output logic                 busy,
  output logic                 done,
  output logic                 err
`ifdef INFSEQ_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cycles
`endif
);

  // Row index width; a single-row array still needs a 1-bit port.
  localparam int RW    = (N > 1) ? $clog2(N) : 1;
  // The run counter must reach LAT+MAX_IN without wrapping.
  localparam int T_MAX = LAT + MAX_IN;
  localparam int T_W   = $clog2(T_MAX + 1);

  localparam logic [CNT_W-1:0] MAX_IN_C = CNT_W'(MAX_IN);
  localparam logic [T_W-1:0]   LAT_T    = T_W'(LAT);
  localparam logic [T_W-1:0]   T_MAX_T  = T_W'(T_MAX);
  localparam logic [RW-1:0]    LAST_ROW = RW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_READY  = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [RW-1:0]    row_reg, row_next;
  logic [T_W-1:0]   t_reg, t_next;
  logic [CNT_W-1:0] num_reg, num_next;
  logic             loaded_reg, loaded_next;
  logic             run_accept;

  // Derived run-window flags, computed from the latched input count.
  logic [T_W-1:0] num_t;
  logic           in_window;
  logic           out_window;
  logic           out_last;
  logic           num_ok;

  assign num_t      = T_W'(num_reg);
  assign in_window  = (t_reg < num_t);
  assign out_window = (t_reg >= LAT_T) && (t_reg < (LAT_T + num_t));
  assign out_last   = (t_reg == (LAT_T + num_t - T_W'(1)));
  assign num_ok     = (num_input != '0) && (num_input <= MAX_IN_C);

  // State and counter registers; stalls hold because next defaults to current.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg  <= S_IDLE;
      row_reg    <= '0;
      t_reg      <= '0;
      num_reg    <= '0;
      loaded_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      row_reg    <= row_next;
      t_reg      <= t_next;
      num_reg    <= num_next;
      loaded_reg <= loaded_next;
    end
  end

  // Next-state logic plus same-cycle (Mealy) strobes for accepted requests.
  always_comb begin
    state_next  = state_reg;
    row_next    = row_reg;
    t_next      = t_reg;
    num_next    = num_reg;
    loaded_next = loaded_reg;
    weight_load = 1'b0;
    input_valid = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    run_accept  = 1'b0;

    if (enable) begin
      unique case (state_reg)
        S_IDLE, S_READY: begin
          if (start_weights) begin
            // Row 0 is on the bus in the accepting cycle.
            weight_load = 1'b1;
            loaded_next = 1'b0;
            if (N == 1) begin
              loaded_next = 1'b1;
              row_next    = '0;
              state_next  = S_READY;
            end else begin
              row_next   = RW'(1);
              state_next = S_LOAD_W;
            end
          end else if (start_array) begin
            if (state_reg == S_READY && num_ok) begin
              // Input vector 0 is consumed in the accepting cycle.
              input_valid = 1'b1;
              run_accept  = 1'b1;
              num_next    = num_input;
              t_next      = T_W'(1);
              state_next  = S_RUN;
            end else begin
              err = 1'b1;
            end
          end
        end

        S_LOAD_W: begin
          weight_load = 1'b1;
          if (row_reg == LAST_ROW) begin
            loaded_next = 1'b1;
            row_next    = '0;
            state_next  = S_READY;
          end else begin
            row_next = row_reg + RW'(1);
          end
        end

        S_RUN: begin
          input_valid = in_window;
          out_valid   = out_window;
          if (out_last) begin
            t_next     = '0;
            state_next = S_DONE;
          end else if (t_reg != T_MAX_T) begin
            t_next = t_reg + T_W'(1);
          end
        end

        S_DONE: begin
          done       = 1'b1;
          state_next = S_READY;
        end

        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // Index and status outputs follow the held registers, so they freeze on stalls.
  always_comb begin
    weight_row     = row_reg;
    weights_loaded = loaded_reg;
    busy           = (state_reg == S_LOAD_W) || (state_reg == S_RUN) ||
                     (state_reg == S_DONE);
    input_idx      = '0;
    out_idx        = '0;
    if (state_reg == S_RUN && in_window) begin
      input_idx = CNT_W'(t_reg);
    end
    if (state_reg == S_RUN && out_window) begin
      out_idx = CNT_W'(t_reg - LAT_T);
    end
  end

`ifdef INFSEQ_STALL_CNT_EN
  logic [15:0] stall_reg;

  // Count stalled busy cycles, restarting at each accepted run and saturating.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      stall_reg <= '0;
    end else if (run_accept) begin
      stall_reg <= '0;
    end else if (!enable && busy && stall_reg != 16'hFFFF) begin
      stall_reg <= stall_reg + 16'd1;
    end
  end

  assign stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_inference_sequencer.sv
// Self-checking bench for inference_sequencer. The expected behaviour is
// written in terms of "enabled cycles since the request was accepted".
// Inputs are driven just after the falling edge and outputs are sampled 1ns later.
module tb_inference_sequencer;

  localparam int N      = 8;
  localparam int MAX_IN = 64;
  localparam int CNT_W  = $clog2(MAX_IN + 1);
  localparam int LAT    = 2 * N - 1;
  localparam int RW     = $clog2(N);

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             enable = 1'b0;
  logic             start_weights = 1'b0;
  logic             start_array = 1'b0;
  logic [CNT_W-1:0] num_input = '0;
  logic             weight_load;
  logic [RW-1:0]    weight_row;
  logic             input_valid;
  logic [CNT_W-1:0] input_idx;
  logic             out_valid;
  logic [CNT_W-1:0] out_idx;
  logic             weights_loaded;
  logic             busy;
  logic             done;
  logic             err;
`ifdef INFSEQ_STALL_CNT_EN
  logic [15:0]      stall_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit model_loaded = 1'b0;

  // {weight_load, input_valid, out_valid, done, err, busy, weights_loaded}
  logic [6:0] obs;
  assign obs = {weight_load, input_valid, out_valid, done, err, busy, weights_loaded};

  inference_sequencer #(.N(N), .MAX_IN(MAX_IN)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .enable         (enable),
    .start_weights  (start_weights),
    .start_array    (start_array),
    .num_input      (num_input),
    .weight_load    (weight_load),
    .weight_row     (weight_row),
    .input_valid    (input_valid),
    .input_idx      (input_idx),
    .out_valid      (out_valid),
    .out_idx        (out_idx),
    .weights_loaded (weights_loaded),
    .busy           (busy),
    .done           (done),
    .err            (err)
`ifdef INFSEQ_STALL_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic en, input logic sw, input logic sa,
                       input logic [CNT_W-1:0] num);
    @(negedge clk);
    enable        = en;
    start_weights = sw;
    start_array   = sa;
    num_input     = num;
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0);
    model_loaded = 1'b0;
    n_cmp++;
    if (obs !== 7'b0 || weight_row !== '0 || input_idx !== '0 || out_idx !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b row=%0d iidx=%0d oidx=%0d exp=0000000/0/0/0",
               obs, weight_row, input_idx, out_idx);
    end
`ifdef INFSEQ_STALL_CNT_EN
    n_cmp++;
    if (stall_cycles !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_stall got=%0d exp=0", stall_cycles);
    end
`endif
    n_rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, '0);
    n_cmp++;
    if (obs !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_idle got=%b exp=0000000", obs);
    end
    $display("reset done");
  endtask

  // Load N rows; row k appears on the k-th enabled cycle after the request.
  task automatic test_weight_load(input int stall_pct);
    int k = 0;
    int guard = 0;
    int cycles = 0;
    logic en;
    logic [6:0] exp;
    while (k < N && guard < 1000) begin
      guard++;
      en = (k == 0) || ($urandom_range(99) >= stall_pct);
      drive(en, k == 0, 1'($urandom_range(1)), CNT_W'($urandom_range(127)));
      cycles++;
      if (en) exp = {1'b1, 4'b0000, k != 0, (k == 0) ? model_loaded : 1'b0};
      else    exp = {5'b00000, 1'b1, 1'b0};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL wload_strobes k=%0d got=%b exp=%b", k, obs, exp);
      end
      if (en) begin
        n_cmp++;
        if (weight_row !== RW'(k)) begin
          n_bad++;
          $display("FAIL wload_row k=%0d got=%0d exp=%0d", k, weight_row, k);
        end
        k++;
      end
    end
    if (guard >= 1000) begin
      n_bad++;
      $display("FAIL wload_timeout got=%0d rows exp=%0d", k, N);
    end
    model_loaded = 1'b1;
    drive(1'b1, 1'b0, 1'b0, '0);
    n_cmp++;
    if (obs !== 7'b0000001) begin
      n_bad++;
      $display("FAIL wload_ready got=%b exp=0000001", obs);
    end
    $display("weight load stall_pct=%0d cycles=%0d", stall_pct, cycles);
  endtask

  // One inference run from READY. k counts enabled cycles since acceptance.
  task automatic test_run(input int num, input int stall_pct, input int stall_at,
                          input bit noise);
    int k;
    int stalls = 0;
    int guard = 0;
    bit did_stall = 1'b0;
    logic en;
    logic [6:0] exp;
    drive(1'b1, 1'b0, 1'b1, CNT_W'(num));
    n_cmp++;
    if (obs !== 7'b0100001 || input_idx !== '0) begin
      n_bad++;
      $display("FAIL run_accept num=%0d got=%b idx=%0d exp=0100001 idx=0",
               num, obs, input_idx);
    end
    k = 1;
    while (k <= LAT + num && guard < 4000) begin
      guard++;
      if (k == stall_at && !did_stall) begin
        en = 1'b0;
        did_stall = 1'b1;
      end else begin
        en = ($urandom_range(99) >= stall_pct);
      end
      drive(en, noise & 1'($urandom_range(1)), noise & 1'($urandom_range(1)),
            noise ? CNT_W'($urandom_range(127)) : CNT_W'(num));
      if (en) exp = {1'b0, k < num, (k >= LAT) && (k < LAT + num), k == LAT + num,
                     1'b0, 1'b1, 1'b1};
      else    exp = {5'b00000, 1'b1, 1'b1};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL run_strobes num=%0d k=%0d en=%0d got=%b exp=%b",
                 num, k, en, obs, exp);
      end
      if (en && k < num) begin
        n_cmp++;
        if (input_idx !== CNT_W'(k)) begin
          n_bad++;
          $display("FAIL run_input_idx k=%0d got=%0d exp=%0d", k, input_idx, k);
        end
      end
      if (en && k >= LAT && k < LAT + num) begin
        n_cmp++;
        if (out_idx !== CNT_W'(k - LAT)) begin
          n_bad++;
          $display("FAIL run_out_idx k=%0d got=%0d exp=%0d", k, out_idx, k - LAT);
        end
      end
      if (en) k++;
      else    stalls++;
    end
    if (guard >= 4000) begin
      n_bad++;
      $display("FAIL run_timeout got k=%0d exp k=%0d", k, LAT + num + 1);
    end
    drive(1'b1, 1'b0, 1'b0, '0);
    n_cmp++;
    if (obs !== 7'b0000001) begin
      n_bad++;
      $display("FAIL run_back_ready got=%b exp=0000001", obs);
    end
`ifdef INFSEQ_STALL_CNT_EN
    n_cmp++;
    if (stall_cycles !== 16'(stalls)) begin
      n_bad++;
      $display("FAIL run_stall_cycles got=%0d exp=%0d", stall_cycles, stalls);
    end
`endif
    $display("run num=%0d stalls=%0d noise=%0d", num, stalls, noise);
  endtask

  // Rejected requests: err pulses and nothing else changes.
  task automatic test_errors();
    logic [CNT_W-1:0] bad;
    drive(1'b1, 1'b0, 1'b1, CNT_W'(3));
    n_cmp++;
    if (obs !== 7'b0000100) begin
      n_bad++;
      $display("FAIL err_idle got=%b exp=0000100", obs);
    end
    drive(1'b0, 1'b0, 1'b1, CNT_W'(3));
    n_cmp++;
    if (obs !== 7'b0000000) begin
      n_bad++;
      $display("FAIL err_idle_stalled got=%b exp=0000000", obs);
    end
    drive(1'b1, 1'b0, 1'b1, CNT_W'(3));
    n_cmp++;
    if (obs !== 7'b0000100) begin
      n_bad++;
      $display("FAIL err_idle_again got=%b exp=0000100", obs);
    end
    test_weight_load(0);
    drive(1'b1, 1'b0, 1'b1, '0);
    n_cmp++;
    if (obs !== 7'b0000101) begin
      n_bad++;
      $display("FAIL err_num_zero got=%b exp=0000101", obs);
    end
    drive(1'b1, 1'b0, 1'b1, CNT_W'(MAX_IN + 1));
    n_cmp++;
    if (obs !== 7'b0000101) begin
      n_bad++;
      $display("FAIL err_num_65 got=%b exp=0000101", obs);
    end
    for (int i = 0; i < 3; i++) begin
      bad = CNT_W'($urandom_range(127, MAX_IN + 1));
      drive(1'b1, 1'b0, 1'b1, bad);
      n_cmp++;
      if (obs !== 7'b0000101) begin
        n_bad++;
        $display("FAIL err_num_big num=%0d got=%b exp=0000101", bad, obs);
      end
    end
    drive(1'b0, 1'b0, 1'b1, '0);
    n_cmp++;
    if (obs !== 7'b0000001) begin
      n_bad++;
      $display("FAIL err_ready_stalled got=%b exp=0000001", obs);
    end
    $display("error requests checked");
  endtask

  // start_weights beats start_array in READY, even with an illegal count.
  task automatic test_priority();
    drive(1'b1, 1'b1, 1'b1, '0);
    n_cmp++;
    if (obs !== 7'b1000001 || weight_row !== '0) begin
      n_bad++;
      $display("FAIL prio_accept got=%b row=%0d exp=1000001 row=0", obs, weight_row);
    end
    for (int r = 1; r < N; r++) begin
      drive(1'b1, 1'b0, 1'b1, CNT_W'(5));
      n_cmp++;
      if (obs !== 7'b1000010 || weight_row !== RW'(r)) begin
        n_bad++;
        $display("FAIL prio_load r=%0d got=%b row=%0d exp=1000010 row=%0d",
                 r, obs, weight_row, r);
      end
    end
    drive(1'b1, 1'b0, 1'b0, '0);
    n_cmp++;
    if (obs !== 7'b0000001) begin
      n_bad++;
      $display("FAIL prio_ready got=%b exp=0000001", obs);
    end
    $display("priority checked");
  endtask

  task automatic test_midrun_reset();
    drive(1'b1, 1'b0, 1'b1, CNT_W'(4));
    for (int k = 1; k < 5; k++) drive(1'b1, 1'b0, 1'b0, '0);
    n_rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0);
    n_rst = 1'b1;
    model_loaded = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0);
    n_cmp++;
    if (obs !== 7'b0 || weight_row !== '0 || input_idx !== '0 || out_idx !== '0) begin
      n_bad++;
      $display("FAIL midrun_reset got=%b row=%0d iidx=%0d oidx=%0d exp=0000000/0/0/0",
               obs, weight_row, input_idx, out_idx);
    end
    drive(1'b1, 1'b0, 1'b1, CNT_W'(3));
    n_cmp++;
    if (obs !== 7'b0000100) begin
      n_bad++;
      $display("FAIL midrun_err got=%b exp=0000100", obs);
    end
    $display("mid-run reset checked");
  endtask

  initial begin
    test_reset();
    test_weight_load(0);
    test_run(3, 0, -1, 1'b0);
    test_run(3, 0, 3, 1'b0);
    test_reset();
    test_errors();
    test_priority();
    test_run(5, 0, -1, 1'b1);
    test_weight_load(30);
    for (int i = 0; i < 6; i++) begin
      test_run($urandom_range(MAX_IN, 1), $urandom_range(30), -1, 1'b1);
    end
    test_run(MAX_IN, 10, -1, 1'b1);
    test_run(1, 20, 1, 1'b1);
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
